// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the matching receiver.
//   uart_state_e : 3-bit frame FSM encoding (IDLE/START/DATA/PARITY/STOP)
//   OVERSAMPLE   : s_tick pulses per bit period
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_tx_parity_if.sv
// Handshake/line bundle for the parity UART transmitter.
//   tx_start, s_tick, din                  : requester -> transmitter
//   tx, tx_busy, tx_done_tick, tx_parity   : transmitter -> requester/line
interface uart_tx_parity_if;

  logic       tx_start;
  logic       s_tick;
  logic [7:0] din;
  logic       tx;
  logic       tx_busy;
  logic       tx_done_tick;
  logic       tx_parity;

  modport master (
    output tx_start, s_tick, din,
    input  tx, tx_busy, tx_done_tick, tx_parity
  );

  modport slave (
    input  tx_start, s_tick, din,
    output tx, tx_busy, tx_done_tick, tx_parity
  );

endinterface

// File: rtl/uart_tx_parity.sv
// Parity-extended UART transmitter: start bit, DBIT data bits LSB-first,
// one parity bit, then a stop period of SB_TICK s_ticks.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of uart_tx_parity_if (tx_start/s_tick/din in;
//           tx/tx_busy/tx_done_tick/tx_parity out)
module uart_tx_parity
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_parity_if.slave   bus
);

  localparam logic [4:0] TICK_LAST = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DBIT - 1);

  uart_state_e state_q, state_d;
  logic [4:0]  tick_q, tick_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done;

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.tx_start) begin
          shift_d  = bus.din;
          parity_d = (^bus.din[DBIT-1:0]) ^ PARITY_ODD;
          tick_d   = '0;
          state_d  = START;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = DATA;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {1'b0, shift_q[7:1]};
            if (bit_q == BIT_LAST) begin
              state_d = PARITY;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      PARITY: begin
        if (bus.s_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            state_d = STOP;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (bus.s_tick) begin
          if (tick_q == STOP_LAST) begin
            tick_d  = '0;
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
        bit_d   = '0;
      end
    endcase

    // Line level is decoded from the next state so the registered tx
    // changes on the same edge as the state it belongs to.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.tx           = tx_q;
  assign bus.tx_busy      = busy_q;
  assign bus.tx_parity    = parity_q;
  // Done is asserted in the cycle the STOP->IDLE move is decided.
  assign bus.tx_done_tick = done;

endmodule

// File: tb/tb_uart_tx_parity.sv
module tb_uart_tx_parity;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } frame_t;

  typedef struct {
    logic [7:0] din;
    logic       par_even;
    logic       par_odd;
  } vec_t;

  logic clk;
  logic rst_n;
  logic s_tick;
  logic tick_en;
  logic div;

  int n_checks;
  int n_fail;

  uart_tx_parity_if bus0 ();
  uart_tx_parity_if bus1 ();

  assign bus0.s_tick = s_tick;
  assign bus1.s_tick = s_tick;

  uart_tx_parity #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(1'b0)) dut_even (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus0)
  );

  uart_tx_parity #(.DBIT(8), .SB_TICK(24), .PARITY_ODD(1'b1)) dut_odd (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus1)
  );

  logic tx_w [2];
  logic busy_w [2];
  logic done_w [2];
  logic par_w [2];
  assign tx_w[0]   = bus0.tx;
  assign tx_w[1]   = bus1.tx;
  assign busy_w[0] = bus0.tx_busy;
  assign busy_w[1] = bus1.tx_busy;
  assign done_w[0] = bus0.tx_done_tick;
  assign done_w[1] = bus1.tx_done_tick;
  assign par_w[0]  = bus0.tx_parity;
  assign par_w[1]  = bus1.tx_parity;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // s_tick every other clock while enabled
  initial begin
    s_tick = 1'b0;
    div    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      div    = ~div;
      s_tick = tick_en & div;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic line_bit(input frame_t f, input int slot);
    if (slot == 0)      return 1'b0;
    else if (slot <= 8) return f.data[slot-1];
    else if (slot == 9) return f.par;
    else                return 1'b1;
  endfunction

  // Scoreboard and line monitor: one expected frame per accepted request
  frame_t exp_q [2][$];
  frame_t cur [2];
  bit     in_frame [2];
  bit     prev_busy [2];
  bit     ferr [2];
  bit     idle_bad [2];
  int     k [2];
  int     done_cnt [2];
  logic [7:0] rxd [2];
  logic       rxp [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int slot;
      int last;
      last = (d == 0) ? 16*10 + 16 - 1 : 16*10 + 24 - 1;
      if (!rst_n) begin
        in_frame[d]  = 1'b0;
        prev_busy[d] = 1'b0;
        exp_q[d].delete();
      end else begin
        if (done_w[d]) done_cnt[d]++;
        if (!in_frame[d] && busy_w[d] && !prev_busy[d]) begin
          if (exp_q[d].size() == 0) begin
            chk($sformatf("unexpected_frame%0d", d), 1, 0);
          end else begin
            cur[d]      = exp_q[d].pop_front();
            in_frame[d] = 1'b1;
            k[d]        = 0;
            ferr[d]     = 1'b0;
            rxd[d]      = '0;
            rxp[d]      = 1'b0;
          end
        end else if (!in_frame[d]) begin
          if (done_w[d]) chk($sformatf("stray_done%0d", d), 1, 0);
          if (tx_w[d] !== 1'b1) idle_bad[d] = 1'b1;
        end
        if (in_frame[d]) begin
          slot = k[d] / 16;
          if (tx_w[d] !== line_bit(cur[d], slot)) ferr[d] = 1'b1;
          if (busy_w[d] !== 1'b1) ferr[d] = 1'b1;
          if (s_tick) begin
            if (k[d] % 16 == 7 && slot >= 1 && slot <= 8) rxd[d][slot-1] = tx_w[d];
            if (k[d] % 16 == 7 && slot == 9) rxp[d] = tx_w[d];
            if (done_w[d] !== (k[d] == last)) ferr[d] = 1'b1;
            if (k[d] == last) begin
              chk($sformatf("frame_line%0d", d), int'(ferr[d]), 0);
              chk($sformatf("rx_data%0d", d), int'(rxd[d]), int'(cur[d].data));
              chk($sformatf("rx_parity%0d", d), int'(rxp[d]), int'(cur[d].par));
              chk($sformatf("tx_parity%0d", d), int'(par_w[d]), int'(cur[d].par));
              in_frame[d] = 1'b0;
            end
            k[d]++;
          end else if (done_w[d]) begin
            ferr[d] = 1'b1;
          end
        end
        prev_busy[d] = busy_w[d];
      end
    end
  end

  task automatic send(input bit en0, input bit en1, input logic [7:0] d,
                      input logic p0, input logic p1);
    frame_t f;
    @(posedge clk);
    #1;
    f.data = d;
    if (en0) begin
      bus0.tx_start = 1'b1;
      bus0.din      = d;
      f.par         = p0;
      exp_q[0].push_back(f);
    end
    if (en1) begin
      bus1.tx_start = 1'b1;
      bus1.din      = d;
      f.par         = p1;
      exp_q[1].push_back(f);
    end
    @(posedge clk);
    #1;
    bus0.tx_start = 1'b0;
    bus1.tx_start = 1'b0;
    bus0.din      = ~d;
    bus1.din      = ~d;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!bus0.tx_busy && !bus1.tx_busy && !in_frame[0] && !in_frame[1]) return;
    end
    chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_k(input int d, input int target);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (in_frame[d] && k[d] >= target) return;
    end
    chk("wait_k_timeout", 1, 0);
  endtask

  vec_t vecs [6];

  initial begin
    int dc0;
    int dc1;
    logic held;
    bit stable;
    logic [7:0] b;
    logic p;

    vecs[0] = '{din: 8'hA5, par_even: 1'b0, par_odd: 1'b1};
    vecs[1] = '{din: 8'h07, par_even: 1'b1, par_odd: 1'b0};
    vecs[2] = '{din: 8'h00, par_even: 1'b0, par_odd: 1'b1};
    vecs[3] = '{din: 8'hFF, par_even: 1'b0, par_odd: 1'b1};
    vecs[4] = '{din: 8'h01, par_even: 1'b1, par_odd: 1'b0};
    vecs[5] = '{din: 8'h80, par_even: 1'b1, par_odd: 1'b0};

    n_checks = 0;
    n_fail   = 0;
    tick_en  = 1'b1;
    rst_n    = 1'b0;
    bus0.tx_start = 1'b0;
    bus1.tx_start = 1'b0;
    bus0.din = '0;
    bus1.din = '0;

    repeat (3) @(negedge clk);
    chk("rst_tx0", int'(bus0.tx), 1);
    chk("rst_busy0", int'(bus0.tx_busy), 0);
    chk("rst_done0", int'(bus0.tx_done_tick), 0);
    chk("rst_parity0", int'(bus0.tx_parity), 0);
    chk("rst_tx1", int'(bus1.tx), 1);
    chk("rst_busy1", int'(bus1.tx_busy), 0);
    chk("rst_done1", int'(bus1.tx_done_tick), 0);
    chk("rst_parity1", int'(bus1.tx_parity), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // table: even-parity/16-tick and odd-parity/24-tick instances in parallel
    for (int i = 0; i < 6; i++) begin
      dc0 = done_cnt[0];
      dc1 = done_cnt[1];
      send(1'b1, 1'b1, vecs[i].din, vecs[i].par_even, vecs[i].par_odd);
      wait_idle();
      chk($sformatf("vec%0d_parity_even", i), int'(bus0.tx_parity), int'(vecs[i].par_even));
      chk($sformatf("vec%0d_parity_odd", i), int'(bus1.tx_parity), int'(vecs[i].par_odd));
      chk($sformatf("vec%0d_done_once", i), done_cnt[0] - dc0 + done_cnt[1] - dc1, 2);
    end

    // start request during DATA is dropped
    dc0 = done_cnt[0];
    send(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
    wait_k(0, 16*4);
    @(posedge clk); #1;
    bus0.tx_start = 1'b1;
    bus0.din      = 8'h3C;
    @(posedge clk); #1;
    bus0.tx_start = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    chk("ignored_start_done_count", done_cnt[0] - dc0, 1);

    // back-to-back: request held through the done cycle, accepted one cycle later
    send(1'b1, 1'b0, 8'hC6, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus0.tx_done_tick) break;
    end
    chk("b2b_done_seen", int'(bus0.tx_done_tick), 1);
    bus0.tx_start = 1'b1;
    bus0.din      = 8'h5A;
    begin
      frame_t f;
      f.data = 8'h5A;
      f.par  = 1'b0;
      exp_q[0].push_back(f);
    end
    @(negedge clk);
    chk("b2b_idle_tx", int'(bus0.tx), 1);
    chk("b2b_idle_busy", int'(bus0.tx_busy), 0);
    @(posedge clk); #1;
    bus0.tx_start = 1'b0;
    @(negedge clk);
    chk("b2b_start_tx", int'(bus0.tx), 0);
    chk("b2b_start_busy", int'(bus0.tx_busy), 1);
    wait_idle();

    // reset during the parity bit
    send(1'b1, 1'b0, 8'hC3, 1'b0, 1'b0);
    wait_k(0, 16*9 + 4);
    dc0 = done_cnt[0];
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", int'(bus0.tx), 1);
    chk("midrst_busy", int'(bus0.tx_busy), 0);
    chk("midrst_done", int'(bus0.tx_done_tick), 0);
    chk("midrst_parity", int'(bus0.tx_parity), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_no_done", done_cnt[0] - dc0, 0);
    send(1'b1, 1'b0, 8'h96, 1'b0, 1'b0);
    wait_idle();
    chk("post_rst_done_once", done_cnt[0] - dc0, 1);

    // no s_tick: line holds
    send(1'b1, 1'b0, 8'h5B, 1'b1, 1'b0);
    wait_k(0, 40);
    tick_en = 1'b0;
    repeat (2) @(negedge clk);
    held   = bus0.tx;
    stable = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (bus0.tx !== held || bus0.tx_busy !== 1'b1) stable = 1'b0;
    end
    chk("stall_stable", int'(stable), 1);
    tick_en = 1'b1;
    wait_idle();

    // random bytes on both instances
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom_range(0, 255));
      p = 1'($countones(b) % 2);
      send(1'b1, 1'b1, b, p, ~p);
      wait_idle();
    end

    chk("idle_line_high0", int'(idle_bad[0]), 0);
    chk("idle_line_high1", int'(idle_bad[1]), 0);
    chk("queue_empty0", exp_q[0].size(), 0);
    chk("queue_empty1", exp_q[1].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
